axi_stream_frame_mux: RTL and testbench

Parametrised N-input AXI4-Stream video multiplexer with frame-safe switching. It sits between several video sources (sensor pipeline, test-pattern generator, overlay path) and the single downstream video consumer. Source changes take effect only on a start-of-frame boundary, so the output never carries a torn frame. Unselected inputs are drained so they never stall their producers.

---
 rtl/axis_frame_mux_pkg.sv | 18 +
 rtl/axis_reg_slice.sv | 58 +++++
 rtl/axi_stream_frame_mux.sv | 156 +++++++++++++++
 tb/tb_axi_stream_frame_mux.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_mux_pkg.sv
// Shared types and helpers for the frame-safe AXI4-Stream video multiplexer.
package axis_frame_mux_pkg;

  // SYNC hunts for a start-of-frame on the active channel; PASS forwards it.
  typedef enum logic {
    SYNC = 1'b0,
    PASS = 1'b1
  } state_t;

  // TUSER bit carrying start-of-frame.
  localparam int SOF_BIT = 0;

  // Channel-select width; a 2-input mux still needs one select bit.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid buffer: registered payload, valid and input ready, full throughput.
module axis_reg_slice #(
  parameter int DATA_W = 24,
  parameter int USER_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  input  logic [USER_W-1:0]   in_user,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic [USER_W-1:0]   out_user,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                empty
);
  localparam int W = DATA_W + DATA_W/8 + 1 + USER_W;

  logic [W-1:0] in_bus;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         main_vld;
  logic         skid_vld;

  assign in_bus    = {in_data, in_keep, in_last, in_user};
  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign {out_data, out_keep, out_last, out_user} = main_q;
  assign empty     = ~main_vld & ~skid_vld;

  // Main entry refills from the skid entry first; the skid entry catches a beat accepted while main is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (~main_vld | out_ready) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= in_valid;
        if (in_valid) main_q <= in_bus;
      end
    end else if (in_valid & ~skid_vld) begin
      skid_q   <= in_bus;
      skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_frame_mux.sv
// N-input AXI4-Stream video mux that only changes source on a start-of-frame.
// Unselected inputs are always drained. Define AXIS_FRAME_MUX_OUT_REG_EN to
// place a 2-entry skid register slice on the output path.
module axi_stream_frame_mux
  import axis_frame_mux_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int DATA_W = 24,
  parameter int USER_W = 1,
  parameter int SEL_W  = sel_w(N_IN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_IN*DATA_W-1:0]   s_tdata_i,
  input  logic [N_IN*DATA_W/8-1:0] s_tkeep_i,
  input  logic [N_IN-1:0]          s_tlast_i,
  input  logic [N_IN*USER_W-1:0]   s_tuser_i,
  input  logic [N_IN-1:0]          s_tvalid_i,
  output logic [N_IN-1:0]          s_tready_o,
  output logic [DATA_W-1:0]        m_tdata_o,
  output logic [DATA_W/8-1:0]      m_tkeep_o,
  output logic                     m_tlast_o,
  output logic [USER_W-1:0]        m_tuser_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  input  logic [SEL_W-1:0]         sel_i,
  output logic [SEL_W-1:0]         active_sel_o,
  output logic                     pending_o,
  output logic                     locked_o
);
  localparam int              KEEP_W = DATA_W/8;
  localparam logic [SEL_W:0]  N_IN_W = (SEL_W+1)'(N_IN);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  active, active_nxt;
  logic [DATA_W-1:0] act_data;
  logic [KEEP_W-1:0] act_keep;
  logic              act_last;
  logic [USER_W-1:0] act_user;
  logic              act_valid;
  logic              act_sof;
  logic              act_ready;
  logic              sel_ok;
  logic              fwd_valid;
  logic              dn_ready;
  logic              dn_empty;
  logic              stall_q;

  assign act_sof      = act_valid & act_user[SOF_BIT];
  assign sel_ok       = {1'b0, sel_i} < N_IN_W;
  assign pending_o    = (sel_i != active) && sel_ok && (state == PASS);
  assign locked_o     = (state == PASS);
  assign active_sel_o = active;

  // Pick out the payload of the channel that currently owns the output
  always_comb begin
    act_data  = '0;
    act_keep  = '0;
    act_last  = 1'b0;
    act_user  = '0;
    act_valid = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (active == SEL_W'(k)) begin
        act_data  = s_tdata_i[k*DATA_W +: DATA_W];
        act_keep  = s_tkeep_i[k*KEEP_W +: KEEP_W];
        act_last  = s_tlast_i[k];
        act_user  = s_tuser_i[k*USER_W +: USER_W];
        act_valid = s_tvalid_i[k];
      end
    end
  end

  // Frame-lock FSM: drain until SOF, forward in PASS, switch only on a fresh SOF
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    fwd_valid  = 1'b0;
    act_ready  = 1'b1;
    case (state)
      SYNC: begin
        if (sel_ok && (sel_i != active)) begin
          active_nxt = sel_i;
        end else if (act_sof) begin
          // Hold the SOF beat; it is forwarded once the output path is empty
          act_ready = 1'b0;
          if (dn_empty) state_nxt = PASS;
        end
      end
      PASS: begin
        // A stalled beat already offered downstream must not be withdrawn
        if (pending_o && act_sof && !stall_q) begin
          act_ready  = 1'b0;
          active_nxt = sel_i;
          state_nxt  = SYNC;
        end else begin
          fwd_valid = act_valid;
          act_ready = dn_ready;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Every channel but the active one is drained unconditionally
  always_comb begin
    s_tready_o = '1;
    for (int k = 0; k < N_IN; k++) begin
      if (active == SEL_W'(k)) s_tready_o[k] = act_ready;
    end
  end

  // State, owning channel and downstream-stall history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= SYNC;
      active  <= '0;
      stall_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      active  <= active_nxt;
      stall_q <= fwd_valid & ~dn_ready;
    end
  end

`ifdef AXIS_FRAME_MUX_OUT_REG_EN
  axis_reg_slice #(
    .DATA_W (DATA_W),
    .USER_W (USER_W)
  ) u_slice (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_data   (act_data),
    .in_keep   (act_keep),
    .in_last   (act_last),
    .in_user   (act_user),
    .in_valid  (fwd_valid),
    .in_ready  (dn_ready),
    .out_data  (m_tdata_o),
    .out_keep  (m_tkeep_o),
    .out_last  (m_tlast_o),
    .out_user  (m_tuser_o),
    .out_valid (m_tvalid_o),
    .out_ready (m_tready_i),
    .empty     (dn_empty)
  );
`else
  assign dn_ready   = m_tready_i;
  assign dn_empty   = 1'b1;
  assign m_tvalid_o = fwd_valid;
  assign m_tdata_o  = locked_o ? act_data : '0;
  assign m_tkeep_o  = locked_o ? act_keep : '0;
  assign m_tlast_o  = locked_o & act_last;
  assign m_tuser_o  = locked_o ? act_user : '0;
`endif

endmodule

// File: tb/tb_axi_stream_frame_mux.sv
// Directed bench for axi_stream_frame_mux (N_IN = 5 so that sel_i = 5 is out of range).
module tb_axi_stream_frame_mux;
  localparam int N  = 5;
  localparam int DW = 24;
  localparam int KW = 3;
  localparam int SW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]  s_tlast, s_tuser, s_tvalid, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [0:0]    m_tuser;
  logic          m_tvalid, m_tready;
  logic [SW-1:0] sel, active_sel;
  logic          pending, locked;

  beat_t chq [N][$];
  beat_t got [$];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    stall_viol = 0;
  int    unsel_viol = 0;
  int    seq = 0;
  bit    bp_en = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;
  beat_t cur_beat;
  logic [N-1:0] hs;

  axi_stream_frame_mux #(.N_IN(N), .DATA_W(DW), .USER_W(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i(s_tdata), .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tlast_o(m_tlast), .m_tuser_o(m_tuser),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .sel_i(sel), .active_sel_o(active_sel), .pending_o(pending), .locked_o(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source drivers (AXI-compliant: hold a beat until accepted) and output monitor
  initial begin
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0; s_tvalid = '0; m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      cur_beat = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (m_tvalid && m_tready) got.push_back(cur_beat);
      if (!rst) begin
        if (prev_stall && (m_tvalid !== 1'b1 || cur_beat !== prev_beat)) stall_viol++;
        for (int k = 0; k < N; k++)
          if (k != int'(active_sel) && s_tready[k] !== 1'b1) unsel_viol++;
      end
      prev_stall = m_tvalid & ~m_tready & ~rst;
      prev_beat  = cur_beat;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && chq[k].size() > 0) chq[k].delete(0);
        if (chq[k].size() > 0) begin
          s_tvalid[k]          = 1'b1;
          s_tdata[k*DW +: DW]  = chq[k][0].data;
          s_tkeep[k*KW +: KW]  = chq[k][0].keep;
          s_tlast[k]           = chq[k][0].last;
          s_tuser[k]           = chq[k][0].user;
        end else begin
          s_tvalid[k] = 1'b0;
        end
      end
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) chq[k].delete();
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    flush();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_frame(input int ch, input int lines, input int bpl, input bit sof, input bit expect_out);
    beat_t b;
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < bpl; i++) begin
        b.data = {8'(ch), 16'(seq)};
        b.keep = 3'(seq) | 3'b001;
        b.last = (i == bpl - 1);
        b.user = sof && (l == 0) && (i == 0);
        seq++;
        chq[ch].push_back(b);
        if (expect_out) exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int  c;
    bit  busy;
    c  = 0;
    ok = 1'b0;
    while (c < bound) begin
      busy = got.size() < exp_q.size();
      for (int k = 0; k < N; k++) if (chq[k].size() > 0) busy = 1'b1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
      c++;
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    sel = '0;
    rst = 1'b1;
    repeat (3) tick();
    flush();
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    n_checks++; if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    n_checks++; if (m_tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep: got %h want 0", m_tkeep); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    n_checks++; if (m_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b want 0", m_tuser); end
    n_checks++; if (active_sel !== 3'd0) begin n_fail++; $display("FAIL reset_active: got %0d want 0", active_sel); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (s_tready !== 5'b11111) begin n_fail++; $display("FAIL reset_tready: got %b want 11111", s_tready); end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL post_reset_locked: got %b want 0", locked); end
  endtask

  task automatic test_frame();
    int c;
    bit ok;
    do_reset();
    sel = 3'd0;
    push_frame(0, 4, 8, 1'b1, 1'b1);
    c = 0;
    @(negedge clk);
    while (!(s_tvalid[0] && s_tuser[0]) && c < 20) begin @(negedge clk); c++; end
    n_checks++; if (c >= 20) begin n_fail++; $display("FAIL frame_sof_seen: waited %0d cycles, limit 20", c); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL frame_locked_at_sof: got %b want 0", locked); end
    n_checks++; if (s_tready[0] !== 1'b0) begin n_fail++; $display("FAIL frame_sof_held: got %b want 0", s_tready[0]); end
    @(negedge clk);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL frame_locked_after_sof: got %b want 1", locked); end
`ifdef AXIS_FRAME_MUX_OUT_REG_EN
    @(negedge clk);
`endif
    n_checks++; if (m_tvalid !== 1'b1 || m_tuser !== 1'b1) begin n_fail++; $display("FAIL frame_first_out: got valid=%b user=%b want 1/1", m_tvalid, m_tuser); end
    wait_idle(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_timeout: got %0d beats want %0d", got.size(), exp_q.size()); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL frame_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_midframe();
    bit ok;
    do_reset();
    sel = 3'd0;
    push_frame(0, 1, 10, 1'b0, 1'b0);
    push_frame(0, 2, 8, 1'b1, 1'b1);
    wait_idle(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_timeout: got %0d beats want %0d", got.size(), exp_q.size()); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_switch();
    int c;
    int badpend;
    bit found;
    bit ok;
    do_reset();
    sel = 3'd0;
    push_frame(0, 2, 4, 1'b1, 1'b1);
    push_frame(0, 2, 4, 1'b1, 1'b0);
    c = 0;
    while (got.size() < 3 && c < 100) begin tick(); c++; end
    sel = 3'd1;
    @(negedge clk);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL switch_pending_set: got %b want 1", pending); end
    c = 0; badpend = 0; found = 1'b0;
    while (c < 50) begin
      if (pending !== 1'b1) badpend++;
      if (s_tvalid[0] && s_tuser[0] && locked) begin found = 1'b1; break; end
      @(negedge clk);
      c++;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL switch_sof_found: got %b want 1", found); end
    n_checks++; if (badpend !== 0) begin n_fail++; $display("FAIL switch_pending_held: got %0d drops want 0", badpend); end
`ifndef AXIS_FRAME_MUX_OUT_REG_EN
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL switch_sof_blocked: got %b want 0", m_tvalid); end
`endif
    @(negedge clk);
    n_checks++; if (active_sel !== 3'd1) begin n_fail++; $display("FAIL switch_active: got %0d want 1", active_sel); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL switch_pending_clear: got %b want 0", pending); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL switch_resync: got %b want 0", locked); end
    tick();
    push_frame(1, 1, 3, 1'b0, 1'b0);
    push_frame(1, 2, 4, 1'b1, 1'b1);
    wait_idle(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL switch_timeout: got %0d beats want %0d", got.size(), exp_q.size()); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL switch_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL switch_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_invalid_sel();
    int c;
    int bad;
    bit ok;
    do_reset();
    sel = 3'd0;
    push_frame(0, 1, 6, 1'b1, 1'b1);
    c = 0;
    while (got.size() < 2 && c < 100) begin tick(); c++; end
    sel = 3'd5;
    bad = 0;
    push_frame(0, 1, 6, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pending !== 1'b0 || active_sel !== 3'd0) bad++;
    end
    tick();
    sel = 3'd7;
    push_frame(0, 1, 6, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pending !== 1'b0 || active_sel !== 3'd0) bad++;
    end
    wait_idle(300, ok);
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL badsel_ignored: got %0d bad cycles want 0", bad); end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL badsel_timeout: got %0d beats want %0d", got.size(), exp_q.size()); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL badsel_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL badsel_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_sel_bounce();
    int c;
    bit ok;
    do_reset();
    sel = 3'd0;
    push_frame(0, 2, 5, 1'b1, 1'b1);
    push_frame(0, 1, 5, 1'b1, 1'b1);
    c = 0;
    while (got.size() < 2 && c < 100) begin tick(); c++; end
    sel = 3'd2;
    @(negedge clk);
    n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL bounce_pending_set: got %b want 1", pending); end
    tick();
    sel = 3'd0;
    @(negedge clk);
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL bounce_pending_clear: got %b want 0", pending); end
    wait_idle(300, ok);
    n_checks++; if (active_sel !== 3'd0) begin n_fail++; $display("FAIL bounce_active: got %0d want 0", active_sel); end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_timeout: got %0d beats want %0d", got.size(), exp_q.size()); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL bounce_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bounce_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    sel = 3'd0;
    stall_viol = 0;
    unsel_viol = 0;
    bp_en = 1'b1;
    push_frame(0, 1, 5, 1'b0, 1'b0);
    push_frame(0, 3, 6, 1'b1, 1'b1);
    push_frame(0, 3, 6, 1'b1, 1'b1);
    push_frame(1, 1, 12, 1'b1, 1'b0);
    push_frame(2, 1, 12, 1'b0, 1'b0);
    push_frame(4, 2, 6, 1'b1, 1'b0);
    wait_idle(1000, ok);
    bp_en = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d beats want %0d", got.size(), exp_q.size()); end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol); end
    n_checks++; if (unsel_viol !== 0) begin n_fail++; $display("FAIL bp_unsel_ready: got %0d violations want 0", unsel_viol); end
    n_checks++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    sel = '0;
    test_reset();
    test_frame();
    test_midframe();
    test_switch();
    test_invalid_sel();
    test_sel_bounce();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
